// File: rtl/adder_tree5_signed_pipe_pkg.sv
// Shared constants and helpers for the five-input signed adder tree.
// Operands are widened by ADDER_TREE_GUARD_BITS so that a sum of five can never overflow.
package adder_tree5_signed_pipe_pkg;

    localparam int ADDER_TREE_GUARD_BITS = 3;

    // Replicated sign bit that is prepended to an operand to widen it without changing its value.
    function automatic logic [ADDER_TREE_GUARD_BITS-1:0] sign_guard(input logic msb);
        return {ADDER_TREE_GUARD_BITS{msb}};
    endfunction

endpackage

// File: rtl/adder_tree5_signed_pipe_signed_add_reg.sv
// Two-operand two's-complement adder with a registered output.
// Callers size W so that the sum is exact.
module signed_add_reg
    import adder_tree5_signed_pipe_pkg::*;
#(
    parameter int W = 20 + ADDER_TREE_GUARD_BITS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else begin
            sum <= a + b;
        end
    end

endmodule

// File: rtl/adder_tree5_signed_pipe.sv
// Five-input signed adder tree over three register stages; one operand set per clock.
// Flow control: in_valid marks a set as live and travels alongside it; there is no ready, nothing stalls.
module adder_tree5_signed_pipe
    import adder_tree5_signed_pipe_pkg::*;
#(
    parameter int WIDTH = 20
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    input  logic [WIDTH-1:0]                       A1,
    input  logic [WIDTH-1:0]                       A2,
    input  logic [WIDTH-1:0]                       A3,
    input  logic [WIDTH-1:0]                       A4,
    input  logic [WIDTH-1:0]                       A5,
    output logic [WIDTH+ADDER_TREE_GUARD_BITS-1:0] S,
    output logic                                   out_valid
);

    localparam int SW = WIDTH + ADDER_TREE_GUARD_BITS;

    logic [SW-1:0] a1_x, a2_x, a3_x, a4_x, a5_x;
    logic [SW-1:0] p12, p34, p5;
    logic [SW-1:0] q, q5;
    logic          v1, v2;

    assign a1_x = {sign_guard(A1[WIDTH-1]), A1};
    assign a2_x = {sign_guard(A2[WIDTH-1]), A2};
    assign a3_x = {sign_guard(A3[WIDTH-1]), A3};
    assign a4_x = {sign_guard(A4[WIDTH-1]), A4};
    assign a5_x = {sign_guard(A5[WIDTH-1]), A5};

    // Stage 1: two pairwise sums; the odd operand rides along.
    signed_add_reg #(.W(SW)) u_add_p12 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a1_x),
        .b     (a2_x),
        .sum   (p12)
    );

    signed_add_reg #(.W(SW)) u_add_p34 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a3_x),
        .b     (a4_x),
        .sum   (p34)
    );

    // Stage 2: combine the pairs.
    signed_add_reg #(.W(SW)) u_add_q (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (p12),
        .b     (p34),
        .sum   (q)
    );

    // Data registers load every cycle; only the valid bit qualifies what S means.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p5        <= '0;
            v1        <= 1'b0;
            q5        <= '0;
            v2        <= 1'b0;
            S         <= '0;
            out_valid <= 1'b0;
        end else begin
            p5        <= a5_x;
            v1        <= in_valid;
            q5        <= p5;
            v2        <= v1;
            S         <= q + q5;
            out_valid <= v2;
        end
    end

endmodule

// File: tb/tb_adder_tree5_signed_pipe.sv
// Directed and random checks of the five-input signed adder tree against a queued sum model.
module tb_adder_tree5_signed_pipe;

    localparam int WIDTH = 20;
    localparam int SW    = WIDTH + 3;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic signed [WIDTH-1:0] a1, a2, a3, a4, a5;
    logic [SW-1:0]           s;
    logic                    out_valid;

    logic [SW-1:0] exp_q[$];
    int            iss_q[$];
    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;

    adder_tree5_signed_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A1        (a1),
        .A2        (a2),
        .A3        (a3),
        .A4        (a4),
        .A5        (a5),
        .S         (s),
        .out_valid (out_valid)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [SW-1:0] model_sum(input int x1, input int x2, input int x3,
                                                input int x4, input int x5);
        int total_sum;
        total_sum = x1 + x2 + x3 + x4 + x5;
        return SW'(total_sum);
    endfunction

    function automatic int rand_op();
        return int'($urandom_range(0, (1 << WIDTH) - 1)) - (1 << (WIDTH - 1));
    endfunction

    // Driver: present one operand set in the low phase; valid sets go on the scoreboard.
    task automatic drive(input logic v, input int x1, input int x2, input int x3,
                         input int x4, input int x5);
        @(negedge clk);
        in_valid = v;
        a1 = WIDTH'(x1);
        a2 = WIDTH'(x2);
        a3 = WIDTH'(x3);
        a4 = WIDTH'(x4);
        a5 = WIDTH'(x5);
        if (v) begin
            exp_q.push_back(model_sum(x1, x2, x3, x4, x5));
            iss_q.push_back(cyc);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, rand_op(), rand_op(), rand_op(), rand_op(), rand_op());
    endtask

    // Scoreboard: every valid output must match the oldest outstanding set, 3 cycles after issue.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", SW'(out_valid), '0);
            end else begin
                logic [SW-1:0] e;
                int            issued;
                e      = exp_q.pop_front();
                issued = iss_q.pop_front();
                check("sum", s, e);
                check("latency", SW'(cyc - issued), SW'(3));
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a1 = '0; a2 = '0; a3 = '0; a4 = '0; a5 = '0;

        // Held in reset with in_valid toggling
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            a1 = WIDTH'(rand_op()); a2 = WIDTH'(rand_op()); a3 = WIDTH'(rand_op());
            a4 = WIDTH'(rand_op()); a5 = WIDTH'(rand_op());
            @(posedge clk);
            #1;
            check("reset_s", s, '0);
            check("reset_valid", SW'(out_valid), '0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Extremes and mixed signs
        drive(1'b1, 524287, 524287, 524287, 524287, 524287);
        idle(4);
        drive(1'b1, -524288, -524288, -524288, -524288, -524288);
        idle(4);
        drive(1'b1, 524287, -524288, 1, -1, 0);
        idle(4);

        // Streaming
        for (int i = 0; i < 50; i++) drive(1'b1, rand_op(), rand_op(), rand_op(), rand_op(), rand_op());
        idle(4);

        // Valid gaps
        drive(1'b1, 1, 2, 3, 4, 5);
        drive(1'b0, rand_op(), rand_op(), rand_op(), rand_op(), rand_op());
        drive(1'b1, -1, -1, -1, -1, -1);
        drive(1'b1, 100, 0, 0, 0, -100);
        drive(1'b0, rand_op(), rand_op(), rand_op(), rand_op(), rand_op());
        idle(4);

        // Asynchronous reset assertion between clock edges
        drive(1'b1, 1, 2, 3, 4, 5);
        idle(2);
        @(posedge clk);
        #1;
        check("pre_async_valid", SW'(out_valid), SW'(1));
        check("pre_async_s", s, SW'(15));
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        iss_q.delete();
        #1;
        check("async_s", s, '0);
        check("async_valid", SW'(out_valid), '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Reset while three sets are in flight
        for (int i = 0; i < 3; i++) drive(1'b1, rand_op(), rand_op(), rand_op(), rand_op(), rand_op());
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        iss_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("midrst_valid", SW'(out_valid), '0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        drive(1'b1, 7, -3, 12, -20, 9);
        idle(5);

        check("drained", SW'(exp_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_tree5_signed_pipe.md
Name: adder_tree5_signed_pipe

Overview:
- Five-input signed adder tree, pipelined over three register stages, producing a full-precision two's-complement sum that never overflows.
- Used wherever several signed partial products or samples must be reduced to one value, for example MAC or filter reduction paths.
- Fully pipelined: it accepts one new operand set per clock and has no stall or back-pressure.

Parameters:
- WIDTH, 20, bit width of each signed input operand (minimum 2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set on A1..A5 is valid this cycle.
- A1  input  WIDTH  signed two's-complement operand 1.
- A2  input  WIDTH  signed operand 2.
- A3  input  WIDTH  signed operand 3.
- A4  input  WIDTH  signed operand 4.
- A5  input  WIDTH  signed operand 5.
- S  output  WIDTH+3  signed sum A1+A2+A3+A4+A5, registered.
- out_valid  output  1  S holds the sum of an accepted operand set.

Behaviour:
- Reset:
  - Asserting rst_n low immediately clears every pipeline register, S and out_valid to 0, without waiting for a clock edge.
  - Release is synchronous to the next clk edge.
- Arithmetic:
  - Every operand is sign-extended to WIDTH+3 bits before any addition.
  - Every intermediate result is held at at least WIDTH+3 bits.
  - The result is exact for all input combinations. Range is ±5·2^(WIDTH-1), which fits in WIDTH+3 bits.
  - No saturation, no wrap, no rounding.
- Stage 1 (registered): p12 = A1+A2, p34 = A3+A4, p5 = A5 (sign-extended), v1 = in_valid.
- Stage 2 (registered): q = p12+p34, q5 = p5, v2 = v1.
- Stage 3 (registered): S = q+q5, out_valid = v2.
- Latency and throughput:
  - Latency is exactly 3 clk cycles from the edge that samples in_valid=1 to the edge after which out_valid=1 and S holds that set's sum.
  - Throughput is one set per cycle.
- Data path is not gated by valid:
  - Data registers load every cycle regardless of in_valid.
  - When out_valid=0, S is don't-care for consumers.
  - Back-to-back valid inputs produce back-to-back valid outputs in order.
- Valid gaps: gaps on in_valid propagate unchanged as gaps on out_valid, delayed by 3 cycles.
- Reset mid-stream: all in-flight sets are discarded and out_valid goes to 0 immediately. The first output after release corresponds to the first in_valid sampled after release.
- No combinational path from any input to any output.

Decomposition:
- Shared package:
  - ADDER_TREE_GUARD_BITS = 3.
  - A helper function for sign-extending WIDTH to WIDTH+3 bits.
- One natural sub-module, signed_add_reg:
  - Parameterised signed adder of two (WIDTH+3)-bit operands with an asynchronous active-low reset output register.
  - Instantiated three times: p12, p34, and the final/q adds.
- Pass-through registers (p5, q5, valid chain) stay in the top level.

Test Plan (WIDTH=20; range -524288..524287; S is 23 bits):
- Reset: hold rst_n=0 with in_valid toggling -> S=0 and out_valid=0 throughout. Drop rst_n asynchronously mid-cycle -> outputs clear without a clk edge.
- Maximum positive: all A=524287, in_valid=1 for one cycle -> 3 cycles later out_valid=1, S=2621435; the next cycle out_valid=0.
- Maximum negative: all A=-524288 -> S=-2621440 (23-bit two's complement 0x580000). Mixed signs A=(524287,-524288,1,-1,0) -> S=-1.
- Streaming: 50 consecutive cycles of random operands with in_valid=1 -> 50 consecutive out_valid cycles, each S equal to the exact signed sum of the set issued 3 cycles earlier, in order.
- Valid gaps: in_valid pattern 1,0,1,1,0 with sets (1,2,3,4,5), X, (-1,-1,-1,-1,-1), (100,0,0,0,-100), X -> out_valid 1,0,1,1,0 from cycle 3, with S = 15, -, -5, 0.
- Reset mid-stream: issue 3 valid sets, pulse rst_n low before any emerges -> no out_valid until a new set is issued after release, which emerges 3 cycles later with the correct sum.
